// File: rtl/aes192_inv_pkg.sv
// Shared constants, types and byte-level helpers for the iterative AES-192 decryptor.
package aes192_inv_pkg;

    localparam int NK     = 6;
    localparam int NR     = 12;
    localparam int NWORDS = 52;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {NOKEY, EXPAND, IDLE, RUN, DONE} state_t;

    // Rcon indexed by i/NK; entry 0 is never used.
    localparam logic [0:8][7:0] RCON = {8'h00, 8'h01, 8'h02, 8'h04, 8'h08,
                                        8'h10, 8'h20, 8'h40, 8'h80};

    // Forward S-box, byte 0 in the most significant position.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // The inverse table is derived from the forward one so the two can never disagree.
    function automatic logic [0:255][7:0] invert_sbox(input logic [0:255][7:0] fwd);
        logic [0:255][7:0] t;
        t = '0;
        for (int i = 0; i < 256; i++) t[fwd[i]] = 8'(i);
        return t;
    endfunction

    localparam logic [0:255][7:0] INV_SBOX = invert_sbox(SBOX);

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    // Four forward S-boxes on a word (the S4 used by key expansion).
    function automatic word_t sub_word(input word_t w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // InvMixColumns on one column; byte 0 (row 0) is the top byte.
    function automatic word_t inv_mix_col(input word_t col);
        logic [7:0] a[4], x2[4], x4[4], x8[4], m9[4], mb[4], md[4], me[4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xt(a[i]);
            x4[i] = xt(x2[i]);
            x8[i] = xt(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

endpackage

// File: rtl/inv_one_round.sv
// One combinational inverse AES round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module inv_one_round
    import aes192_inv_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rk_i,
    input  logic         final_i,
    output logic [127:0] state_o
);

    logic [127:0] sr_sb;
    logic [127:0] ark;
    logic [127:0] mix;

    // Byte b = 4*col + row; row r rotates right by r, fused with the inverse S-box.
    always_comb begin
        sr_sb = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_sb[127-8*(4*c+r) -: 8] = INV_SBOX[state_i[127-8*(4*((c-r+4)%4)+r) -: 8]];
            end
        end
    end

    assign ark = sr_sb ^ rk_i;

    // Column-wise InvMixColumns after the key has been added.
    always_comb begin
        mix = '0;
        for (int c = 0; c < 4; c++) mix[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
    end

    assign state_o = final_i ? ark : mix;

endmodule

// File: rtl/aes_192_inv_iter.sv
// Iterative AES-192 decryptor: expands the key one word per cycle into a local store,
// then runs one inverse round per clock. Optional macro AES192_INV_ZEROIZE_EN adds a
// zeroize input that wipes the key store and output register from NOKEY/IDLE/DONE.
module aes_192_inv_iter
    import aes192_inv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [191:0] key,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef AES192_INV_ZEROIZE_EN
    input  logic         zeroize,
`endif
    output logic         key_ok
);

    state_t             state_q, state_d;
    word_t [NWORDS-1:0] w_q, w_d;
    logic [5:0]         idx_q, idx_d;      // next key word to write
    logic [2:0]         kmod_q, kmod_d;    // idx mod NK
    logic [3:0]         rci_q, rci_d;      // idx / NK
    logic [3:0]         rnd_q, rnd_d;
    logic [127:0]       blk_q, blk_d;
    logic [127:0]       out_q, out_d;
    logic               ovld_q, ovld_d;
    logic               kok_q, kok_d;

    logic               zero_req;
    word_t              prev_w, temp_w;
    logic [127:0]       rk_last, rk_rnd, round_out;

`ifdef AES192_INV_ZEROIZE_EN
    // Honoured only while no expansion or block is in flight.
    assign zero_req = zeroize & ((state_q == NOKEY) | (state_q == IDLE) | (state_q == DONE));
`else
    assign zero_req = 1'b0;
`endif

    assign rk_last = {w_q[4*NR], w_q[4*NR+1], w_q[4*NR+2], w_q[4*NR+3]};
    assign rk_rnd  = {w_q[{rnd_q, 2'd0}], w_q[{rnd_q, 2'd1}], w_q[{rnd_q, 2'd2}], w_q[{rnd_q, 2'd3}]};

    assign prev_w = w_q[idx_q - 6'd1];
    assign temp_w = (kmod_q == 3'd0) ? (sub_word(rot_word(prev_w)) ^ {RCON[rci_q], 24'h0}) : prev_w;

    inv_one_round u_round (
        .state_i (blk_q),
        .rk_i    (rk_rnd),
        .final_i (rnd_q == 4'd0),
        .state_o (round_out)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= NOKEY;
        else     state_q <= state_d;
    end

    // FSM next state; a key offered in IDLE wins over a simultaneous block.
    always_comb begin
        state_d = state_q;
        case (state_q)
            NOKEY:   if (key_valid) state_d = EXPAND;
            EXPAND:  if (idx_q == 6'(NWORDS-1)) state_d = IDLE;
            IDLE:    if (key_valid) state_d = EXPAND;
                     else if (in_valid) state_d = RUN;
            RUN:     if (rnd_q == 4'd0) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = NOKEY;
        endcase
        if (zero_req) state_d = NOKEY;
    end

    // FSM outputs. in_ready stays high in IDLE even when a key is offered;
    // in that cycle the key is taken and the block is left for later.
    always_comb begin
        key_ready = (state_q == NOKEY) || (state_q == IDLE);
        in_ready  = (state_q == IDLE);
    end

    // Datapath next state: key load/expansion, block whitening and rounds, output hold.
    always_comb begin
        w_d    = w_q;
        idx_d  = idx_q;
        kmod_d = kmod_q;
        rci_d  = rci_q;
        rnd_d  = rnd_q;
        blk_d  = blk_q;
        out_d  = out_q;
        ovld_d = ovld_q;
        kok_d  = kok_q;
        case (state_q)
            NOKEY, IDLE: begin
                if (key_valid) begin
                    for (int k = 0; k < NK; k++) w_d[k] = key[191-32*k -: 32];
                    idx_d  = 6'(NK);
                    kmod_d = 3'd0;
                    rci_d  = 4'd1;
                    kok_d  = 1'b0;
                end else if ((state_q == IDLE) && in_valid) begin
                    blk_d = in_data ^ rk_last;
                    rnd_d = 4'(NR-1);
                end
            end
            EXPAND: begin
                w_d[idx_q] = w_q[idx_q - 6'd6] ^ temp_w;
                idx_d      = idx_q + 6'd1;
                kmod_d     = (kmod_q == 3'd5) ? 3'd0 : kmod_q + 3'd1;
                rci_d      = (kmod_q == 3'd5) ? rci_q + 4'd1 : rci_q;
                if (idx_q == 6'(NWORDS-1)) kok_d = 1'b1;
            end
            RUN: begin
                blk_d = round_out;
                if (rnd_q == 4'd0) begin
                    out_d  = round_out;
                    ovld_d = 1'b1;
                end else begin
                    rnd_d = rnd_q - 4'd1;
                end
            end
            DONE: if (out_ready) ovld_d = 1'b0;
            default: ;
        endcase
        if (zero_req) begin
            w_d    = '0;
            out_d  = '0;
            kok_d  = 1'b0;
            ovld_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q    <= '0;
            idx_q  <= '0;
            kmod_q <= '0;
            rci_q  <= '0;
            rnd_q  <= '0;
            blk_q  <= '0;
            out_q  <= '0;
            ovld_q <= 1'b0;
            kok_q  <= 1'b0;
        end else begin
            w_q    <= w_d;
            idx_q  <= idx_d;
            kmod_q <= kmod_d;
            rci_q  <= rci_d;
            rnd_q  <= rnd_d;
            blk_q  <= blk_d;
            out_q  <= out_d;
            ovld_q <= ovld_d;
            kok_q  <= kok_d;
        end
    end

    assign out_data  = out_q;
    assign out_valid = ovld_q;
    assign key_ok    = kok_q;

endmodule

// File: tb/tb_aes_192_inv_iter.sv
// Scoreboard bench for aes_192_inv_iter using FIPS-197 and SP800-38A AES-192 vectors.
module tb_aes_192_inv_iter;

    localparam logic [191:0] KEY_C2 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] CT_C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] PT_C2  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [191:0] KEY2   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] CT1    = 128'hbd334f1d6e45f25ff712a214571fa5cc;
    localparam logic [127:0] PT1    = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT2    = 128'h974104846d0ad3ad7734ecb3ecee4eef;
    localparam logic [127:0] PT2    = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

    logic         clk = 1'b0;
    logic         rst;
    logic [191:0] key;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         key_ok;
`ifdef AES192_INV_ZEROIZE_EN
    logic         zeroize;
`endif

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q[$];

    aes_192_inv_iter dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef AES192_INV_ZEROIZE_EN
        .zeroize   (zeroize),
`endif
        .key_ok    (key_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output is compared against the oldest expected plaintext.
    initial begin
        logic [127:0] e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("plaintext", out_data, e);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic load_key(input logic [191:0] k);
        key = k;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    // Edges after the key handshake until key_ok is seen.
    task automatic wait_key_ok(output int n);
        n = 0;
        while (key_ok !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Issues one block (caller ensures IDLE) and counts edges until out_valid.
    task automatic send_block(input logic [127:0] ct, output int lat);
        in_data = ct;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        int n, lat;
        logic [127:0] held;
        logic ok;
        rst = 1'b1; key = '0; key_valid = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
`ifdef AES192_INV_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        @(negedge clk);
        check("rst_key_ok", 128'(key_ok), 128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd0);
        check("rst_key_ready", 128'(key_ready), 128'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Key expansion: 46 cycles, last word from FIPS-197 A.2.
        load_key(KEY2);
        check("expand_key_ready", 128'(key_ready), 128'd0);
        check("expand_in_ready", 128'(in_ready), 128'd0);
        wait_key_ok(n);
        check("expand_cycles", 128'(n), 128'd46);
        check("w51", 128'(dut.w_q[51]), 128'h01002202);
        check("idle_in_ready", 128'(in_ready), 128'd1);
        check("idle_key_ready", 128'(key_ready), 128'd1);

        // Two blocks with free-flowing output; out_valid 12 edges after the accept edge.
        exp_q.push_back(PT1);
        send_block(CT1, lat);
        check("latency", 128'(lat), 128'd12);
        @(posedge clk); #1;
        check("done_to_idle_in_ready", 128'(in_ready), 128'd1);
        exp_q.push_back(PT2);
        send_block(CT2, lat);
        check("latency2", 128'(lat), 128'd12);
        @(posedge clk); #1;

        // Backpressure: output held 20 cycles, no input accepted.
        out_ready = 1'b0;
        exp_q.push_back(PT1);
        send_block(CT1, lat);
        held = out_data;
        ok = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0 || key_ready !== 1'b0) ok = 1'b0;
        end
        check("backpressure_stable", 128'(ok), 128'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_out_valid", 128'(out_valid), 128'd0);
        check("release_in_ready", 128'(in_ready), 128'd1);
        check("out_data_held", out_data, PT1);

        // Key and block together in IDLE: key wins, block dropped.
        key = KEY_C2; key_valid = 1'b1;
        in_data = CT_C2; in_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0; in_valid = 1'b0;
        check("collide_key_ok", 128'(key_ok), 128'd0);
        check("collide_in_ready", 128'(in_ready), 128'd0);
        wait_key_ok(n);
        check("reexpand_cycles", 128'(n), 128'd46);
        exp_q.push_back(PT_C2);
        send_block(CT_C2, lat);
        check("latency_c2", 128'(lat), 128'd12);
        @(posedge clk); #1;
        drain();

        // Reset while RUN is at round 5.
        in_data = CT_C2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        check("midrst_key_ok", 128'(key_ok), 128'd0);
        check("midrst_key_ready", 128'(key_ready), 128'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        in_data = CT_C2; in_valid = 1'b1;
        ok = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) ok = 1'b0;
        end
        check("nokey_ignores_input", 128'(ok), 128'd1);
        load_key(KEY_C2);
        if (in_ready !== 1'b0) ok = 1'b0;
        wait_key_ok(n);
        check("expand_ignores_input", 128'(ok), 128'd1);
        check("post_rst_expand", 128'(n), 128'd46);
        exp_q.push_back(PT_C2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

`ifdef AES192_INV_ZEROIZE_EN
        // Zeroize in RUN is ignored; in IDLE it wipes the key.
        exp_q.push_back(PT_C2);
        in_data = CT_C2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        zeroize = 1'b1;
        repeat (5) @(posedge clk);
        #1 zeroize = 1'b0;
        drain();
        check("zero_run_key_ok", 128'(key_ok), 128'd1);
        zeroize = 1'b1;
        @(posedge clk); #1;
        zeroize = 1'b0;
        check("zero_idle_key_ok", 128'(key_ok), 128'd0);
        check("zero_idle_in_ready", 128'(in_ready), 128'd0);
        check("zero_idle_out_data", out_data, 128'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
